// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 Hz timing constants and RGB565 colour definitions
// for the timing generator and the pixel/picture generators.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_SYNC  = 96;
    localparam int H_BACK  = 48;
    localparam int H_VALID = 640;
    localparam int H_FRONT = 16;

    localparam int V_SYNC  = 2;
    localparam int V_BACK  = 33;
    localparam int V_VALID = 480;
    localparam int V_FRONT = 10;

    localparam logic SYNC_POL = 1'b0;

    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int H_ACT0  = H_SYNC + H_BACK;
    localparam int V_ACT0  = V_SYNC + V_BACK;

    typedef logic [CNT_W-1:0] coord_t;
    typedef logic [15:0]      rgb565_t;

    // Coordinate value meaning "no pixel requested this cycle".
    localparam coord_t PIX_NONE = '1;

    localparam rgb565_t RGB_BLACK   = 16'h0000;
    localparam rgb565_t RGB_WHITE   = 16'hFFFF;
    localparam rgb565_t RGB_RED     = 16'hF800;
    localparam rgb565_t RGB_GREEN   = 16'h07E0;
    localparam rgb565_t RGB_BLUE    = 16'h001F;
    localparam rgb565_t RGB_YELLOW  = 16'hFFE0;
    localparam rgb565_t RGB_CYAN    = 16'h07FF;
    localparam rgb565_t RGB_MAGENTA = 16'hF81F;

    function automatic rgb565_t rgb565(input logic [4:0] r, input logic [5:0] g,
                                       input logic [4:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One scan axis: a 10-bit counter running 0..MAX when enabled, with a wrap
// strobe on the enabled cycle that returns it to zero.
module vga_axis_cnt
    import vga_timing_pkg::*;
#(
    parameter int MAX = H_TOTAL - 1
) (
    input  logic             vga_clk,
    input  logic             sys_rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);

    assign wrap = en && (cnt == CNT_MAX);

    // NOTE: reset is sampled on the clock edge, and state uses <= so every
    // counter in the design updates from pre-edge values.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_ctrl.sv
// VGA timing generator: scans h/v counters, drives sync and RGB565, and
// requests pixels from the generator one clock ahead of display.
module vga_ctrl #(
    parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int   H_BACK   = vga_timing_pkg::H_BACK,
    parameter int   H_VALID  = vga_timing_pkg::H_VALID,
    parameter int   H_FRONT  = vga_timing_pkg::H_FRONT,
    parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int   V_BACK   = vga_timing_pkg::V_BACK,
    parameter int   V_VALID  = vga_timing_pkg::V_VALID,
    parameter int   V_FRONT  = vga_timing_pkg::V_FRONT,
    parameter logic SYNC_POL = vga_timing_pkg::SYNC_POL
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic [15:0] rgb,
    output logic        frame_start
);

    import vga_timing_pkg::coord_t;
    import vga_timing_pkg::PIX_NONE;
    import vga_timing_pkg::RGB_BLACK;

    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int H_ACT0  = H_SYNC + H_BACK;
    localparam int V_ACT0  = V_SYNC + V_BACK;

    localparam coord_t H_SYNC_END = coord_t'(H_SYNC);
    localparam coord_t V_SYNC_END = coord_t'(V_SYNC);
    localparam coord_t H_VIS_LO   = coord_t'(H_ACT0);
    localparam coord_t H_VIS_HI   = coord_t'(H_ACT0 + H_VALID);
    localparam coord_t H_REQ_LO   = coord_t'(H_ACT0 - 1);
    localparam coord_t H_REQ_HI   = coord_t'(H_ACT0 + H_VALID - 1);
    localparam coord_t V_VIS_LO   = coord_t'(V_ACT0);
    localparam coord_t V_VIS_HI   = coord_t'(V_ACT0 + V_VALID);

    coord_t h_cnt;
    coord_t v_cnt;
    logic   h_wrap;
    logic   v_wrap;
    logic   v_vis;
    logic   pix_req;
    logic   rgb_valid;

    vga_axis_cnt #(
        .MAX(H_TOTAL - 1)
    ) u_h_cnt (
        .vga_clk(vga_clk),
        .sys_rst(sys_rst),
        .en     (1'b1),
        .cnt    (h_cnt),
        .wrap   (h_wrap)
    );

    // The vertical axis only advances, and only wraps, on the line wrap.
    vga_axis_cnt #(
        .MAX(V_TOTAL - 1)
    ) u_v_cnt (
        .vga_clk(vga_clk),
        .sys_rst(sys_rst),
        .en     (h_wrap),
        .cnt    (v_cnt),
        .wrap   (v_wrap)
    );

    assign hsync = (h_cnt < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    assign vsync = (v_cnt < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;

    assign v_vis     = (v_cnt >= V_VIS_LO) && (v_cnt < V_VIS_HI);
    assign rgb_valid = v_vis && (h_cnt >= H_VIS_LO) && (h_cnt < H_VIS_HI);
    assign pix_req   = v_vis && (h_cnt >= H_REQ_LO) && (h_cnt < H_REQ_HI);

    assign pix_x = pix_req ? (h_cnt - H_REQ_LO) : PIX_NONE;
    assign pix_y = pix_req ? (v_cnt - V_VIS_LO) : PIX_NONE;

    // The generator's registered colour arrives exactly one clock after its
    // request, so the data path to the pins stays combinational.
    assign rgb = rgb_valid ? pix_data : RGB_BLACK;

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= v_wrap;
        end
    end

endmodule
